bsg_nor_n_pipe: RTL

Parametrised, pipelined N-input bitwise NOR/OR reducer with valid/ready flow control on both sides. It generalises the fixed 3-input, 16-bit NOR in four ways: input count and width are parameters, each input can be masked per beat, OR mode is selectable, and the datapath runs through an elastic register pipeline. It sits between a producer and a consumer datapath and absorbs backpressure without losing or duplicating beats.

---
 rtl/bsg_nor_n_pipe.sv | 60 ++++++
 1 files changed

// File: rtl/bsg_nor_n_pipe.sv
// bsg_nor_n_pipe: masked N-input bitwise NOR/OR reducer feeding an elastic valid/ready register pipeline.
module bsg_nor_n_pipe #(
    parameter int width_p  = 16,
    parameter int els_p    = 3,
    parameter int stages_p = 2
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       v_i,
    output logic                       ready_o,
    input  logic [els_p*width_p-1:0]   data_i,
    input  logic [els_p-1:0]           mask_i,
    input  logic                       invert_i,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    input  logic                       ready_i
);
    localparam int last_lp = stages_p - 1;

    logic [width_p-1:0] red;
    logic [stages_p-1:0] v, load;
    logic [width_p-1:0] d [stages_p];

    always_comb begin
        red = '0;
        for (int k = 0; k < els_p; k++)
            red = red | (mask_i[k] ? data_i[k*width_p +: width_p] : '0);
        red = invert_i ? ~red : red;
    end

    // A stage may load iff the consumer takes a beat or some stage at or after it is empty.
    always_comb begin
        load = '0;
        for (int s = 0; s < stages_p; s++) begin
            load[s] = ready_i;
            for (int t = s; t < stages_p; t++)
                load[s] = load[s] | ~v[t];
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v <= '0;
            for (int s = 0; s < stages_p; s++)
                d[s] <= '0;
        end else begin
            for (int s = 0; s < stages_p; s++) begin
                if (load[s]) begin
                    v[s] <= (s == 0) ? v_i : v[(s == 0) ? 0 : s-1];
                    if ((s == 0) ? v_i : v[(s == 0) ? 0 : s-1])
                        d[s] <= (s == 0) ? red : d[(s == 0) ? 0 : s-1];
                end
            end
        end
    end

    assign ready_o = load[0];
    assign v_o     = v[last_lp];
    assign data_o  = d[last_lp];
endmodule
